anneal_accept_ctrl: RTL and testbench
=====================================

# anneal_accept_ctrl

Sequencing controller for the simulated-annealing acceptance datapath. Takes candidate tour-cost pairs (new/old), issues them to `prob_computer` with the current inverse temperature, and waits for the acceptance probability. It then draws an LFSR random number and emits an accept/reject decision. It also owns the cooling schedule: it advances `Tinv` every `ITERS_PER_TEMP` decisions and signals completion.

## Interface
- `ITERS_PER_TEMP`, 1024: decisions per temperature step; legal range 1..65536.
- `TIMEOUT`, 255: maximum cycles spent in WAIT before a forced reject; 1..255.
- `LFSR_SEED`, 32'hACE12345: LFSR reset value; must be nonzero.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: pulse; loads `tinv` from `tinv_init`, clears the iteration counter and `done`, and enters IDLE.
- `tinv_init` in 32: initial inverse temperature.
- `tinv_step` in 32: amount added to `tinv` per temperature step.
- `tinv_max` in 32: stop threshold.
- `cand_valid` in 1 / `cand_ready` out 1: candidate handshake.
- `cand_new`, `cand_old` in 32: unsigned tour costs.
- `pc_valid` out 1: one-cycle issue pulse to `prob_computer.inp_valid`.
- `pc_new`, `pc_old`, `pc_tinv` out 32: registered operands, held stable from ISSUE until the return to IDLE.
- `pc_out` in 32: probability, unsigned Q8.24.
- `pc_out_valid` in 1: result strobe.
- `dec_valid` out 1: one-cycle decision pulse.
- `dec_accept` out 1: decision value; valid only while `dec_valid` is high.
- `tinv` out 32: current inverse temperature.
- `done` out 1: schedule finished.
- `timeout_err` out 1: sticky flag, set by any WAIT timeout.

## Operation
- States: STOP (reset state), IDLE, ISSUE, WAIT, DECIDE.
- STOP:
  - `cand_ready`=0.
  - `start` → IDLE.
  - `pc_out_valid` is ignored.
- IDLE:
  - `cand_ready`=1.
  - On handshake, latch `cand_new`/`cand_old`.
  - Fast path (macro enabled, `cand_new` <= `cand_old`): accept → DECIDE.
  - Otherwise → ISSUE.
- ISSUE:
  - `pc_valid`=1 for exactly one cycle.
  - Load `pc_tinv` from `tinv`.
  - Clear the timeout counter.
  - → WAIT.
- WAIT:
  - On `pc_out_valid`: accept iff {8'h00, `lfsr[23:0]`} < `pc_out` (unsigned compare) → DECIDE.
  - If the counter reaches `TIMEOUT` first: reject, set `timeout_err` → DECIDE.
  - `pc_out_valid` and timeout in the same cycle: `pc_out_valid` wins.
- DECIDE:
  - `dec_valid`=1 and `dec_accept` is driven.
  - The LFSR advances one step, only here.
  - The iteration counter increments.
  - On wrap (ITERS_PER_TEMP-1 → 0), `tinv` += `tinv_step`, saturating at 32'hFFFFFFFF.
  - If the updated `tinv` >= `tinv_max`: set `done` → STOP.
  - Otherwise → IDLE.
- `start` in any non-STOP state is ignored. A pulse that occurs mid-run is not queued.
- LFSR: 32-bit Galois, taps 0x80200003 (x^32+x^22+x^2+x+1), shift right, XOR taps when the LSB is 1.
- A `pc_out_valid` arriving outside WAIT is dropped; no decision is produced from it.

## Timing
- Reset values:
  - state=STOP; `cand_ready`, `pc_valid`, `dec_valid`, `dec_accept`, `done`, `timeout_err` = 0.
  - `pc_new`/`pc_old`/`pc_tinv`/`tinv` = 0.
  - `lfsr`=`LFSR_SEED`; counters = 0.
- Reset mid-operation aborts any in-flight request. A late `prob_computer` result lands in STOP and is ignored.
- `cand_ready` is a registered state decode. It is never high in the cycle after a handshake.
- Fast path: handshake at cycle N → `dec_valid` at N+1 → `cand_ready` at N+2.
- Slow path: handshake at N → `pc_valid` at N+1 → `pc_out_valid` at M → `dec_valid` at M+1 → `cand_ready` at M+2.
- Timeout: `dec_valid` at N+2+TIMEOUT when no result arrives.
- `tinv` and `done` update at the clock edge ending the DECIDE cycle. Both are visible at N+2 / M+2.
- Throughput: at most one decision per 2 cycles (fast) or per 3 + `prob_computer` latency (slow).

## Configuration
- `ANNEAL_FASTPATH_EN` defined:
  - Improving or equal moves (`cand_new` <= `cand_old`) skip `prob_computer`.
  - They are accepted unconditionally; the LFSR still advances in DECIDE.
- Undefined:
  - Every candidate goes IDLE→ISSUE→WAIT.
  - Improving moves rely on `pc_out` >= 1.0 (Q8.24 0x01000000) for acceptance.

## Test plan
- Reset then `start` with `tinv_init`=100, `tinv_step`=10, `tinv_max`=130, ITERS_PER_TEMP=2, fast-path candidates (new=5, old=9) → every handshake accepted; `tinv` goes 110, 120, 130; `done`=1 after decision 6; `cand_ready` stays 0.
- Candidate new=20, old=10; model returns `pc_out`=0x00000000 after 7 cycles → `pc_valid` one cycle after handshake with `pc_tinv`=`tinv`; `dec_valid` one cycle after `pc_out_valid`; `dec_accept`=0.
- Same candidate with `pc_out`=0x01000000 → `dec_accept`=1 for every LFSR value. Repeat 1000× with `pc_out`=0x00800000 → acceptance rate 0.5±0.05.
- Model never responds, TIMEOUT=255 → `dec_valid` at handshake+257 with `dec_accept`=0 and `timeout_err`=1. A later `pc_out_valid` in IDLE → no `dec_valid`.
- Assert `rst` low while in WAIT, release, pulse `pc_out_valid` → state STOP, all outputs at reset values, no `dec_valid`.
- Build without `ANNEAL_FASTPATH_EN`; candidate new=3, old=9 → `pc_valid` is issued; the decision waits for `pc_out_valid`.

Source files
------------

// File: rtl/anneal_accept_ctrl.sv
// anneal_accept_ctrl: annealing accept/reject sequencer with LFSR draw and cooling schedule.
// Optional ANNEAL_FASTPATH_EN: improving or equal moves bypass prob_computer and are accepted.
module anneal_accept_ctrl #(
    parameter int unsigned ITERS_PER_TEMP = 1024,
    parameter int unsigned TIMEOUT = 255,
    parameter logic [31:0] LFSR_SEED = 32'hACE12345
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] tinv_init,
    input  logic [31:0] tinv_step,
    input  logic [31:0] tinv_max,
    input  logic        cand_valid,
    output logic        cand_ready,
    input  logic [31:0] cand_new,
    input  logic [31:0] cand_old,
    output logic        pc_valid,
    output logic [31:0] pc_new,
    output logic [31:0] pc_old,
    output logic [31:0] pc_tinv,
    input  logic [31:0] pc_out,
    input  logic        pc_out_valid,
    output logic        dec_valid,
    output logic        dec_accept,
    output logic [31:0] tinv,
    output logic        done,
    output logic        timeout_err
);
    typedef enum logic [2:0] {STOP, IDLE, ISSUE, WAIT, DECIDE} state_t;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [16:0] ITER_LAST = 17'(ITERS_PER_TEMP - 1);
    state_t state, state_nx;
    logic [31:0] lfsr;
    logic [16:0] iter;
    logic [7:0] tcnt;
    logic acc, fast, wrap, tmo;
    logic [32:0] tinv_sum;
    logic [31:0] tinv_nx;
`ifdef ANNEAL_FASTPATH_EN
    assign fast = cand_new <= cand_old;
`else
    assign fast = 1'b0;
`endif
    assign cand_ready = state == IDLE;
    assign pc_valid = state == ISSUE;
    assign dec_valid = state == DECIDE;
    assign dec_accept = dec_valid & acc;
    assign tmo = tcnt == TMO_LAST;
    assign wrap = iter == ITER_LAST;
    assign tinv_sum = {1'b0, tinv} + {1'b0, tinv_step};
    assign tinv_nx = !wrap ? tinv : tinv_sum[32] ? 32'hFFFFFFFF : tinv_sum[31:0];
    always_comb begin
        state_nx = state;
        case (state)
            STOP:    state_nx = start ? IDLE : STOP;
            IDLE:    state_nx = !cand_valid ? IDLE : fast ? DECIDE : ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = (pc_out_valid || tmo) ? DECIDE : WAIT;
            DECIDE:  state_nx = tinv_nx >= tinv_max ? STOP : IDLE;
            default: state_nx = STOP;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= STOP;
        else state <= state_nx;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_new <= '0;
            pc_old <= '0;
            pc_tinv <= '0;
            tinv <= '0;
            done <= 1'b0;
            timeout_err <= 1'b0;
            lfsr <= LFSR_SEED;
            iter <= '0;
            tcnt <= '0;
            acc <= 1'b0;
        end else begin
            case (state)
                STOP: if (start) begin
                    tinv <= tinv_init;
                    iter <= '0;
                    done <= 1'b0;
                end
                // operands are captured at the handshake so they are already stable while pc_valid is high
                IDLE: if (cand_valid) begin
                    pc_new <= cand_new;
                    pc_old <= cand_old;
                    acc <= 1'b1;
                    if (!fast) pc_tinv <= tinv;
                end
                ISSUE: tcnt <= '0;
                WAIT: begin
                    if (pc_out_valid) acc <= {8'h00, lfsr[23:0]} < pc_out;
                    else if (tmo) begin
                        acc <= 1'b0;
                        timeout_err <= 1'b1;
                    end else tcnt <= tcnt + 8'd1;
                end
                DECIDE: begin
                    lfsr <= lfsr[0] ? (lfsr >> 1) ^ 32'h80200003 : lfsr >> 1;
                    iter <= wrap ? '0 : iter + 17'd1;
                    tinv <= tinv_nx;
                    if (tinv_nx >= tinv_max) done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_anneal_accept_ctrl.sv
// tb_anneal_accept_ctrl: randomized self-checking bench against a behavioural decision/schedule model.
module tb_anneal_accept_ctrl;
    localparam int ITERS = 2;
    localparam int TMO = 255;
    localparam logic [31:0] SEED = 32'hACE12345;
    logic clk = 0, rst = 0, start = 0, cand_valid = 0, pc_out_valid = 0;
    logic [31:0] tinv_init = 0, tinv_step = 0, tinv_max = 0, cand_new = 0, cand_old = 0, pc_out = 0;
    logic cand_ready, pc_valid, dec_valid, dec_accept, done, timeout_err;
    logic [31:0] pc_new, pc_old, pc_tinv, tinv;
    int checks = 0, failures = 0;
    logic [31:0] m_lfsr, m_tinv, m_step, m_max;
    int m_iter;
    bit m_done, m_terr;
    anneal_accept_ctrl #(.ITERS_PER_TEMP(ITERS), .TIMEOUT(TMO), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst(rst), .start(start), .tinv_init(tinv_init), .tinv_step(tinv_step),
        .tinv_max(tinv_max), .cand_valid(cand_valid), .cand_ready(cand_ready), .cand_new(cand_new),
        .cand_old(cand_old), .pc_valid(pc_valid), .pc_new(pc_new), .pc_old(pc_old), .pc_tinv(pc_tinv),
        .pc_out(pc_out), .pc_out_valid(pc_out_valid), .dec_valid(dec_valid), .dec_accept(dec_accept),
        .tinv(tinv), .done(done), .timeout_err(timeout_err)
    );
    always #5 clk = ~clk;
    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return v[0] ? (v >> 1) ^ 32'h80200003 : v >> 1;
    endfunction
    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdy"}, cand_ready, 0);
        check({tag, "_pcv"}, pc_valid, 0);
        check({tag, "_dv"}, dec_valid, 0);
        check({tag, "_da"}, dec_accept, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_terr"}, timeout_err, 0);
        check({tag, "_pcn"}, pc_new, 0);
        check({tag, "_pco"}, pc_old, 0);
        check({tag, "_pct"}, pc_tinv, 0);
        check({tag, "_tinv"}, tinv, 0);
    endtask
    task automatic start_run(input logic [31:0] i, input logic [31:0] s, input logic [31:0] m);
        tinv_init = i;
        tinv_step = s;
        tinv_max = m;
        start = 1;
        @(negedge clk);
        start = 0;
        m_tinv = i;
        m_step = s;
        m_max = m;
        m_iter = 0;
        m_done = 0;
        check("start_tinv", tinv, i);
        check("start_done", done, 0);
        check("start_rdy", cand_ready, 1);
    endtask
    task automatic wait_ready();
        int n = 0;
        while (!cand_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready", cand_ready, 1);
    endtask
    // lat = 0 means prob_computer never answers
    task automatic cand(input logic [31:0] nw, input logic [31:0] od, input int lat,
                        input logic [31:0] pout, output bit acc_seen);
        bit exp_acc, fastp;
        int n;
`ifdef ANNEAL_FASTPATH_EN
        fastp = nw <= od;
`else
        fastp = 0;
`endif
        wait_ready();
        cand_valid = 1;
        cand_new = nw;
        cand_old = od;
        @(negedge clk);
        cand_valid = 0;
        check("ready_drop", cand_ready, 0);
        if (fastp) begin
            exp_acc = 1;
            check("fast_nopc", pc_valid, 0);
        end else begin
            check("pc_valid", pc_valid, 1);
            check("pc_new", pc_new, nw);
            check("pc_old", pc_old, od);
            check("pc_tinv", pc_tinv, m_tinv);
            check("dec_early", dec_valid, 0);
            if (lat == 0) begin
                n = 0;
                while (!dec_valid && n < 400) begin
                    @(negedge clk);
                    n++;
                end
                check("tmo_lat", n, TMO + 1);
                m_terr = 1;
                exp_acc = 0;
            end else begin
                for (int i = 0; i < lat; i++) begin
                    @(negedge clk);
                    if (i == 0) check("pc_pulse", pc_valid, 0);
                    check("wait_nodec", dec_valid, 0);
                end
                pc_out_valid = 1;
                pc_out = pout;
                @(negedge clk);
                pc_out_valid = 0;
                exp_acc = {8'h00, m_lfsr[23:0]} < pout;
            end
        end
        check("dec_valid", dec_valid, 1);
        check("dec_accept", dec_accept, exp_acc);
        check("terr", timeout_err, m_terr);
        acc_seen = dec_accept;
        m_lfsr = lfsr_next(m_lfsr);
        m_iter++;
        if (m_iter % ITERS == 0)
            m_tinv = (m_step > 32'hFFFFFFFF - m_tinv) ? 32'hFFFFFFFF : m_tinv + m_step;
        if (m_tinv >= m_max) m_done = 1;
        @(negedge clk);
        check("dec_pulse", dec_valid, 0);
        check("tinv", tinv, m_tinv);
        check("done", done, m_done);
        check("post_rdy", cand_ready, !m_done);
    endtask
    initial begin
        bit a;
        int accs;
        m_lfsr = SEED;
        m_terr = 0;
        @(negedge clk);
        check_reset_outputs("rst");
        rst = 1;
        pc_out_valid = 1;
        @(negedge clk);
        pc_out_valid = 0;
        @(negedge clk);
        check("stop_nodec", dec_valid, 0);
        check("stop_rdy", cand_ready, 0);
        // schedule: 100 -> 110 -> 120 -> 130, done after decision 6
        start_run(100, 10, 130);
        for (int k = 0; k < 6; k++) begin
            cand(5, 9, 1, 32'h01000000, a);
            check("sched_acc", a, 1);
        end
        repeat (3) @(negedge clk);
        check("sched_rdy", cand_ready, 0);
        check("sched_done", done, 1);
        start_run(100, 0, 32'hFFFFFFFF);
        tinv_init = 555;
        start = 1;
        @(negedge clk);
        start = 0;
        check("start_ignored", tinv, 100);
        cand(20, 10, 7, 32'h00000000, a);
        check("p0_rej", a, 0);
        cand(20, 10, 3, 32'h01000000, a);
        check("p1_acc", a, 1);
        accs = 0;
        for (int k = 0; k < 1000; k++) begin
            cand(20, 10, 1, 32'h00800000, a);
            accs += int'(a);
        end
        check("rate", (accs >= 450 && accs <= 550), 1);
        cand(20, 10, TMO, 32'h01000000, a);
        check("edge_acc", a, 1);
        cand(20, 10, 0, 32'h01000000, a);
        check("tmo_rej", a, 0);
        pc_out_valid = 1;
        pc_out = 32'h01000000;
        @(negedge clk);
        pc_out_valid = 0;
        check("idle_drop", dec_valid, 0);
        @(negedge clk);
        check("idle_drop2", dec_valid, 0);
        check("idle_rdy", cand_ready, 1);
        cand(3, 9, 2, 32'h00000000, a);
        for (int k = 0; k < 200; k++)
            cand($urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(1, 8),
                 $urandom & 32'h01FFFFFF, a);
        wait_ready();
        cand_valid = 1;
        cand_new = 50;
        cand_old = 10;
        @(negedge clk);
        cand_valid = 0;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        check_reset_outputs("mid");
        rst = 1;
        pc_out_valid = 1;
        @(negedge clk);
        pc_out_valid = 0;
        @(negedge clk);
        check_reset_outputs("late");
        m_lfsr = SEED;
        m_terr = 0;
        start_run(32'hFFFFFFF0, 32'h20, 32'hFFFFFFFF);
        cand(20, 10, 2, 32'h00400000, a);
        cand(20, 10, 2, 32'h00C00000, a);
        check("sat_tinv", tinv, 32'hFFFFFFFF);
        check("sat_done", done, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
